// File: rtl/apu_pkg.sv
// Shared types for the address-pattern sequencer.
package apu_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } apu_state_e;

  // Configuration register selector carried on cfg_field.
  typedef enum logic [1:0] {
    CfgBase   = 2'd0,
    CfgStride = 2'd1,
    CfgTrip   = 2'd2,
    CfgRsvd   = 2'd3
  } cfg_field_e;

endpackage

// File: rtl/apu_loop_counter.sv
// One nesting level of the odometer: index register, trip compare and carry-out.
module apu_loop_counter #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            inc,
  input  logic [BITS-1:0] trip,
  output logic            at_last,
  output logic            carry
);

  logic [BITS-1:0] idx_d, idx_q;

  // Last-iteration detect; a trip of zero behaves like a trip of one.
  always_comb begin
    if (trip == '0) begin
      at_last = (idx_q == '0);
    end else begin
      at_last = (idx_q == (trip - BITS'(1)));
    end
    carry = inc & at_last;
  end

  // Advance on inc, wrapping to zero on the last iteration.
  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = at_last ? '0 : idx_q + BITS'(1);
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/apu_seq.sv
// Nested-loop address sequencer: APU_CNT channels share one LOOP_CNT-deep odometer and
// stream base + sum(idx * stride) per channel, built purely from adders.
module apu_seq
  import apu_pkg::*;
#(
  parameter int unsigned BITS         = 8,
  parameter int unsigned LOG_LOOP_CNT = 1,
  parameter int unsigned LOG_APU_CNT  = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cfg_we,
  input  logic [1:0]                          cfg_field,
  input  logic [LOG_APU_CNT-1:0]              cfg_apu,
  input  logic [LOG_LOOP_CNT-1:0]             cfg_loop,
  input  logic [BITS-1:0]                     cfg_data,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic [(2**LOG_APU_CNT)*BITS-1:0]    out_addr,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done
);

  localparam int unsigned LOOP_CNT = 2 ** LOG_LOOP_CNT;
  localparam int unsigned APU_CNT  = 2 ** LOG_APU_CNT;

  apu_state_e state_d, state_q;
  logic       valid_d, valid_q;
  logic       busy_d, busy_q;
  logic       done_d, done_q;

  logic [BITS-1:0] base_d   [APU_CNT];
  logic [BITS-1:0] base_q   [APU_CNT];
  logic [BITS-1:0] stride_d [APU_CNT][LOOP_CNT];
  logic [BITS-1:0] stride_q [APU_CNT][LOOP_CNT];
  logic [BITS-1:0] trip_d   [LOOP_CNT];
  logic [BITS-1:0] trip_q   [LOOP_CNT];

  // acc[k][l] = base_k + sum over m >= l of idx_m * stride_{k,m}; acc[k][0] is the live address.
  logic [BITS-1:0] acc_d [APU_CNT][LOOP_CNT];
  logic [BITS-1:0] acc_q [APU_CNT][LOOP_CNT];

  logic [LOOP_CNT-1:0] inc;
  logic [LOOP_CNT-1:0] at_last;
  logic [LOOP_CNT-1:0] carry;

  logic cfg_en;
  logic launch;
  logic fire;

  // Qualify the control events for the current state.
  always_comb begin
    cfg_en = (state_q == StIdle) && cfg_we;
    launch = (state_q == StIdle) && start;
    // abort wins over a simultaneous handshake
    fire   = (state_q == StRun) && valid_q && out_ready && !abort;
  end

  // Odometer: level 0 steps on each accepted beat, higher levels on the carry below.
  for (genvar l = 0; l < LOOP_CNT; l++) begin : g_lvl
    if (l == 0) begin : g_first
      assign inc[l] = fire;
    end else begin : g_next
      assign inc[l] = carry[l-1];
    end

    apu_loop_counter #(
      .BITS (BITS)
    ) u_lvl (
      .clk     (clk),
      .reset   (reset),
      .clear   (launch),
      .inc     (inc[l]),
      .trip    (trip_q[l]),
      .at_last (at_last[l]),
      .carry   (carry[l])
    );
  end

  // Next state and registered status flags.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (fire && carry[LOOP_CNT-1]) begin
          // carry out of the outermost level marks the final beat
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    valid_d = (state_d == StRun);
    busy_d  = (state_d == StRun);
    done_d  = (state_d == StDone);
  end

  // Configuration writes, accepted only while idle.
  always_comb begin
    base_d   = base_q;
    stride_d = stride_q;
    trip_d   = trip_q;
    if (cfg_en) begin
      unique case (cfg_field_e'(cfg_field))
        CfgBase:   base_d[cfg_apu] = cfg_data;
        CfgStride: stride_d[cfg_apu][cfg_loop] = cfg_data;
        CfgTrip:   trip_d[cfg_loop] = cfg_data;
        CfgRsvd:   ;
        default:   ;
      endcase
    end
  end

  // Incremental address update: the level that increments adds its stride and reloads all
  // inner accumulators, which restarts them at the new outer position.
  always_comb begin
    acc_d = acc_q;
    if (launch) begin
      for (int k = 0; k < APU_CNT; k++) begin
        for (int l = 0; l < LOOP_CNT; l++) begin
          acc_d[k][l] = base_d[k];
        end
      end
    end else begin
      for (int j = 0; j < LOOP_CNT; j++) begin
        if (inc[j] && !at_last[j]) begin
          for (int k = 0; k < APU_CNT; k++) begin
            for (int l = 0; l <= j; l++) begin
              acc_d[k][l] = acc_q[k][j] + stride_q[k][j];
            end
          end
        end
      end
    end
  end

  // State, configuration and accumulator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < APU_CNT; k++) begin
        base_q[k] <= '0;
        for (int l = 0; l < LOOP_CNT; l++) begin
          stride_q[k][l] <= '0;
          acc_q[k][l]    <= '0;
        end
      end
      for (int l = 0; l < LOOP_CNT; l++) begin
        trip_q[l] <= '0;
      end
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      trip_q   <= trip_d;
      acc_q    <= acc_d;
    end
  end

  // Output mapping; channel 0 occupies the least significant bits.
  always_comb begin
    out_addr = '0;
    for (int k = 0; k < APU_CNT; k++) begin
      out_addr[k*BITS +: BITS] = acc_q[k][0];
    end
    out_valid = valid_q;
    out_last  = valid_q & (&at_last);
    busy      = busy_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_apu_seq.sv
// Self-checking bench for apu_seq: a beat-index model checked every cycle plus literal pins.
module tb_apu_seq;

  logic        clk;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_field;
  logic        cfg_apu;
  logic        cfg_loop;
  logic [7:0]  cfg_data;
  logic        start;
  logic        abort;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_addr;
  logic        out_last;
  logic        busy;
  logic        done;

  apu_seq #(
    .BITS         (8),
    .LOG_LOOP_CNT (1),
    .LOG_APU_CNT  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_field (cfg_field),
    .cfg_apu   (cfg_apu),
    .cfg_loop  (cfg_loop),
    .cfg_data  (cfg_data),
    .start     (start),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int MIdle = 0;
  localparam int MRun  = 1;
  localparam int MDone = 2;

  int         m_state = MIdle;
  bit         m_init = 0;
  bit         m_after_reset = 0;
  int         m_beat = 0;
  int         m_total = 1;
  logic [7:0] m_base   [2];
  logic [7:0] m_stride [2][2];
  logic [7:0] m_trip   [2];

  function automatic int eff_trip(input int l);
    return (m_trip[l] == 8'd0) ? 1 : int'(m_trip[l]);
  endfunction

  // Address of beat n for channel k, from the closed-form sum.
  function automatic logic [7:0] exp_addr(input int k, input int n);
    int rem = n;
    int sum = int'(m_base[k]);
    for (int l = 0; l < 2; l++) begin
      sum += (rem % eff_trip(l)) * int'(m_stride[k][l]);
      rem  = rem / eff_trip(l);
    end
    return 8'(sum);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_state = MIdle;
      m_init = 1;
      m_after_reset = 1;
      for (int k = 0; k < 2; k++) begin
        m_base[k] = 8'd0;
        for (int l = 0; l < 2; l++) m_stride[k][l] = 8'd0;
      end
      for (int l = 0; l < 2; l++) m_trip[l] = 8'd0;
    end else if (m_init) begin
      case (m_state)
        MIdle: begin
          if (cfg_we) begin
            case (cfg_field)
              2'd0: m_base[cfg_apu] = cfg_data;
              2'd1: m_stride[cfg_apu][cfg_loop] = cfg_data;
              2'd2: m_trip[cfg_loop] = cfg_data;
              default: ;
            endcase
          end
          if (start) begin
            m_state = MRun;
            m_beat = 0;
            m_total = eff_trip(0) * eff_trip(1);
            m_after_reset = 0;
          end
        end
        MRun: begin
          if (abort) m_state = MIdle;
          else if (out_ready) begin
            if (m_beat == m_total - 1) m_state = MDone;
            else m_beat++;
          end
        end
        default: m_state = MIdle;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare + capture ----------------
  logic [7:0] cap0[$];
  logic [7:0] cap1[$];
  logic       cap_last[$];
  int         done_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      check("out_valid", 32'(out_valid), 32'(m_state == MRun));
      check("busy", 32'(busy), 32'(m_state == MRun));
      check("done", 32'(done), 32'(m_state == MDone));
      if (m_state == MRun) begin
        check("addr_ch0", 32'(out_addr[7:0]), 32'(exp_addr(0, m_beat)));
        check("addr_ch1", 32'(out_addr[15:8]), 32'(exp_addr(1, m_beat)));
        check("out_last", 32'(out_last), 32'(m_beat == m_total - 1));
      end else begin
        check("out_last_idle", 32'(out_last), 32'd0);
        if (m_after_reset) check("addr_after_reset", 32'(out_addr), 32'd0);
      end
      if (out_valid && out_ready && !abort && !reset) begin
        cap0.push_back(out_addr[7:0]);
        cap1.push_back(out_addr[15:8]);
        cap_last.push_back(out_last);
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cfg_write(input logic [1:0] f, input logic a, input logic l,
                           input logic [7:0] d);
    cfg_we = 1'b1; cfg_field = f; cfg_apu = a; cfg_loop = l; cfg_data = d;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  task automatic clear_caps();
    cap0.delete();
    cap1.delete();
    cap_last.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int c = 0;
    while (m_state != MIdle && c < max_cyc) begin
      cyc(1);
      c++;
    end
    check("wait_idle_timeout", 32'(m_state == MIdle), 32'd1);
  endtask

  task automatic cfg_basic();
    cfg_write(2'd0, 1'b0, 1'b0, 8'd0);
    cfg_write(2'd1, 1'b0, 1'b0, 8'd1);
    cfg_write(2'd1, 1'b0, 1'b1, 8'd2);
    cfg_write(2'd0, 1'b1, 1'b0, 8'd0);
    cfg_write(2'd1, 1'b1, 1'b0, 8'd3);
    cfg_write(2'd1, 1'b1, 1'b1, 8'd4);
    cfg_write(2'd2, 1'b0, 1'b0, 8'd2);
    cfg_write(2'd2, 1'b0, 1'b1, 8'd2);
  endtask

  task automatic check_basic_caps(input string tag);
    logic [7:0] e0 [4];
    logic [7:0] e1 [4];
    e0 = '{8'd0, 8'd1, 8'd2, 8'd3};
    e1 = '{8'd0, 8'd3, 8'd4, 8'd7};
    check({tag, "_beats"}, 32'(cap0.size()), 32'd4);
    for (int i = 0; i < 4 && i < cap0.size(); i++) begin
      check({tag, "_ch0"}, 32'(cap0[i]), 32'(e0[i]));
      check({tag, "_ch1"}, 32'(cap1[i]), 32'(e1[i]));
      check({tag, "_last"}, 32'(cap_last[i]), 32'(i == 3));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    logic [7:0] w0 [6];
    reset = 1'b1; cfg_we = 1'b0; cfg_field = 2'd0; cfg_apu = 1'b0; cfg_loop = 1'b0;
    cfg_data = 8'd0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    cyc(2);
    reset = 1'b0;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_addr", 32'(out_addr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    cyc(1);

    // Basic two-level sweep.
    cfg_basic();
    clear_caps();
    d0 = done_cnt;
    pulse_start();
    wait_idle(40);
    check_basic_caps("basic");
    check("basic_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Backpressure on the second beat.
    clear_caps();
    pulse_start();
    cyc(1);
    out_ready = 1'b0;
    cyc(1);
    check("stall_addr", 32'(out_addr), 32'h0301);
    cyc(2);
    check("stall_addr_held", 32'(out_addr), 32'h0301);
    out_ready = 1'b1;
    wait_idle(40);
    check_basic_caps("bp");

    // Modular wrap with a negative outer stride.
    cfg_write(2'd0, 1'b0, 1'b0, 8'd250);
    cfg_write(2'd1, 1'b0, 1'b0, 8'd3);
    cfg_write(2'd1, 1'b0, 1'b1, 8'hFF);
    cfg_write(2'd2, 1'b0, 1'b0, 8'd3);
    clear_caps();
    pulse_start();
    wait_idle(40);
    w0 = '{8'd250, 8'd253, 8'd0, 8'd249, 8'd252, 8'd255};
    check("wrap_beats", 32'(cap0.size()), 32'd6);
    for (int i = 0; i < 6 && i < cap0.size(); i++) begin
      check("wrap_ch0", 32'(cap0[i]), 32'(w0[i]));
    end

    // Abort on the second beat, then replay.
    clear_caps();
    d0 = done_cnt;
    pulse_start();
    cyc(1);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    cyc(3);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_beats", 32'(cap0.size()), 32'd1);
    clear_caps();
    pulse_start();
    wait_idle(40);
    check("replay_beats", 32'(cap0.size()), 32'd6);
    if (cap0.size() > 0) check("replay_first", 32'(cap0[0]), 32'd250);

    // start and cfg_we during RUN are ignored.
    clear_caps();
    pulse_start();
    cyc(1);
    start = 1'b1; cfg_we = 1'b1; cfg_field = 2'd0; cfg_apu = 1'b0; cfg_data = 8'd100;
    cyc(1);
    start = 1'b0; cfg_we = 1'b0;
    wait_idle(40);
    check("ignored_beats", 32'(cap0.size()), 32'd6);
    clear_caps();
    pulse_start();
    wait_idle(40);
    if (cap0.size() > 0) check("ignored_cfg_base", 32'(cap0[0]), 32'd250);

    // Zero trips give one beat at base.
    cfg_write(2'd2, 1'b0, 1'b0, 8'd0);
    cfg_write(2'd2, 1'b0, 1'b1, 8'd0);
    clear_caps();
    pulse_start();
    wait_idle(20);
    check("trip0_beats", 32'(cap0.size()), 32'd1);
    if (cap0.size() > 0) begin
      check("trip0_ch0", 32'(cap0[0]), 32'd250);
      check("trip0_ch1", 32'(cap1[0]), 32'd0);
      check("trip0_last", 32'(cap_last[0]), 32'd1);
    end

    // Reset in the middle of a run.
    cfg_write(2'd2, 1'b0, 1'b0, 8'd3);
    pulse_start();
    cyc(1);
    reset = 1'b1;
    cyc(1);
    check("midreset_valid", 32'(out_valid), 32'd0);
    check("midreset_addr", 32'(out_addr), 32'd0);
    check("midreset_last", 32'(out_last), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    reset = 1'b0;
    cyc(1);
    clear_caps();
    pulse_start();
    wait_idle(20);
    check("postreset_beats", 32'(cap0.size()), 32'd1);
    if (cap0.size() > 0) begin
      check("postreset_addr", {16'd0, cap1[0], cap0[0]}, 32'd0);
      check("postreset_last", 32'(cap_last[0]), 32'd1);
    end

    // Config write in the same cycle as start is used by that sequence.
    clear_caps();
    cfg_we = 1'b1; cfg_field = 2'd0; cfg_apu = 1'b0; cfg_data = 8'd7; start = 1'b1;
    cyc(1);
    cfg_we = 1'b0; start = 1'b0;
    wait_idle(20);
    check("samecyc_beats", 32'(cap0.size()), 32'd1);
    if (cap0.size() > 0) check("samecyc_ch0", 32'(cap0[0]), 32'd7);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apu_seq.md
APU_SEQ -- requirements
Module: apu_seq

Interface
REQ-001 Parameter BITS, default 8, address/stride/trip width.
REQ-002 Parameter LOG_LOOP_CNT, default 1; LOOP_CNT = 2**LOG_LOOP_CNT nested loop levels, level 0 innermost.
REQ-003 Parameter LOG_APU_CNT, default 1; APU_CNT = 2**LOG_APU_CNT address channels.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 cfg_we  in  1  config write strobe.
REQ-007 cfg_field  in  2  0=base, 1=stride, 2=trip, 3=reserved (write ignored).
REQ-008 cfg_apu  in  LOG_APU_CNT  target channel for base/stride; ignored for trip.
REQ-009 cfg_loop  in  LOG_LOOP_CNT  target level for stride/trip; ignored for base.
REQ-010 cfg_data  in  BITS  value; strides are two's complement.
REQ-011 start  in  1  launch sequence.
REQ-012 abort  in  1  cancel running sequence.
REQ-013 out_ready  in  1  consumer accepts beat.
REQ-014 out_valid  out  1  beat present.
REQ-015 out_addr  out  APU_CNT*BITS  all channel addresses, channel 0 in LSBs.
REQ-016 out_last  out  1  final beat of sequence.
REQ-017 busy  out  1  high in RUN.
REQ-018 done  out  1  one-cycle pulse after last beat accepted.

Function
REQ-019 Per channel k: addr_k = base_k + sum over l of idx_l*stride_{k,l}, modulo 2**BITS.
REQ-020 Trip value t gives t iterations of that level; t=0 is treated as 1.
REQ-021 Indices advance odometer-style: idx_0 first; on its wrap, the next level increments, and so on.
REQ-022 Beat count per sequence is the product of effective trips; out_last is high on the beat with every idx_l = trip_l-1.
REQ-023 FSM states IDLE, RUN, DONE; reset enters IDLE.
REQ-024 IDLE: start -> RUN; out_valid rises the following cycle with all indices 0.
REQ-025 RUN: a beat transfers on out_valid && out_ready; the next beat is presented the following cycle, sustaining one beat per cycle.
REQ-026 While out_valid && !out_ready, out_addr and out_last are held stable.
REQ-027 RUN: transfer of the out_last beat -> DONE; out_valid drops the next cycle.
REQ-028 DONE lasts exactly one cycle with done=1, then -> IDLE.
REQ-029 RUN: abort -> IDLE next cycle; out_valid drops, no done pulse; abort takes priority over a simultaneous transfer.
REQ-030 start is ignored in RUN and DONE; abort is ignored in IDLE and DONE.
REQ-031 cfg_we is honoured only in IDLE; writes in RUN/DONE are dropped; configuration is sampled as held at start.
REQ-032 A cfg_we and start in the same IDLE cycle: the write lands and is used by that sequence.
REQ-033 No multipliers: addresses are updated incrementally by adders.

Reset
REQ-034 Reset in any state -> IDLE next edge; out_valid, out_last, busy, done = 0; out_addr = 0.
REQ-035 Reset clears all base, stride, and trip registers to 0 and all indices to 0.

Structure
REQ-036 Package apu_pkg holds the state enum (IDLE/RUN/DONE) and the cfg_field enum.
REQ-037 Sub-module apu_loop_counter: one level's index, trip compare, and wrap/carry-out; instantiated LOOP_CNT times.

Verification (BITS=8, LOOP_CNT=2, APU_CNT=2)
REQ-038 Basic: base0=0, strides0={1,2}; base1=0, strides1={3,4}; trips={2,2}; start with out_ready=1 -> ch0 0,1,2,3 and ch1 0,3,4,7; out_last on beat 4; done one cycle later.
REQ-039 Backpressure: same config, out_ready low for 3 cycles at beat 2 -> beat 2 (ch0=1, ch1=3) held stable; sequence completes unchanged.
REQ-040 Wrap and negative stride: base0=250, stride0={3,-1}, trips={3,2} -> ch0 250,253,0,249,252,255.
REQ-041 Abort: abort asserted at beat 2 -> IDLE next cycle, out_valid=0, done never pulses; a fresh start replays from beat 1.
REQ-042 Ignored inputs: start and cfg_we during RUN -> no restart, configuration unchanged on the next sequence; trip=0 yields a single beat at base.
REQ-043 Reset mid-RUN -> all outputs 0 next cycle; a start with no configuration yields one beat with out_addr=0 and out_last=1.
